// File: rtl/exhaustive_sweep_capture_if.sv
// Stimulus/response bundle between a sweep controller and the capture stage.
// Capture outputs are registered; start/abort are level inputs sampled on the clock edge.
interface exhaustive_sweep_capture_if #(
  parameter int W = 5
);
  logic              start;
  logic              abort;
  logic              dut_out;
  logic [W-1:0]      pattern;
  logic              busy;
  logic              done;
  logic [2**W-1:0]   truth_table;
  logic [15:0]       signature;
  logic [W:0]        ones_count;

  modport master (
    output start, abort, dut_out,
    input  pattern, busy, done, truth_table, signature, ones_count
  );

  modport slave (
    input  start, abort, dut_out,
    output pattern, busy, done, truth_table, signature, ones_count
  );
endinterface

// File: rtl/exhaustive_sweep_capture.sv
// Exhaustive stimulus sweep: each pattern held DWELL cycles, response sampled on the last cycle.
// Sweep takes 2^W*DWELL cycles; no backpressure, abort stops it on the next edge keeping partial results.
module exhaustive_sweep_capture #(
  parameter int          W     = 5,
  parameter int          DWELL = 2,
  parameter logic [15:0] POLY  = 16'h1021,
  parameter logic [15:0] SEED  = 16'hFFFF
) (
  input logic                  CK,
  input logic                  reset,
  exhaustive_sweep_capture_if.slave bus
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST_DWELL = CW'(DWELL - 1);
  localparam logic [W-1:0]  LAST_PAT   = {W{1'b1}};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]      state;
  logic [CW-1:0]   dwell_cnt;
  logic [W-1:0]    pattern_q;
  logic            busy_q;
  logic            done_q;
  logic [2**W-1:0] table_q;
  logic [15:0]     sig_q;
  logic [W:0]      ones_q;

  logic            sample;
  logic            last_pat;
  logic [15:0]     sig_next;

  assign sample   = (dwell_cnt == LAST_DWELL);
  assign last_pat = (pattern_q == LAST_PAT);
  assign sig_next = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? POLY : 16'h0000) ^ {15'b0, bus.dut_out};

  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      dwell_cnt <= '0;
      pattern_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      table_q   <= '0;
      sig_q     <= SEED;
      ones_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            pattern_q <= '0;
            dwell_cnt <= '0;
            table_q   <= '0;
            sig_q     <= SEED;
            ones_q    <= '0;
            busy_q    <= 1'b1;
            state     <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          // abort beats a coinciding final sample, so a cut sweep never pulses done
          if (bus.abort) begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else if (!sample) begin
            dwell_cnt <= dwell_cnt + CW'(1);
          end else begin
            table_q[pattern_q] <= bus.dut_out;
            ones_q             <= ones_q + {{W{1'b0}}, bus.dut_out};
            sig_q              <= sig_next;
            if (last_pat) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= S_DONE;
            end else begin
              pattern_q <= pattern_q + W'(1);
              dwell_cnt <= '0;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pattern     = pattern_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.truth_table = table_q;
  assign bus.signature   = sig_q;
  assign bus.ones_count  = ones_q;

endmodule

// File: tb/tb_exhaustive_sweep_capture.sv
// Bench for exhaustive_sweep_capture: three instances (defaults, SEED=0, DWELL=3) against a sweep model.
module tb_exhaustive_sweep_capture;
  localparam int          W    = 5;
  localparam int          N    = 32;
  localparam logic [15:0] POLY = 16'h1021;
  localparam int          DWS[3]   = '{2, 2, 3};
  localparam logic [15:0] SEEDS[3] = '{16'hFFFF, 16'h0000, 16'hFFFF};

  localparam logic [1:0] M_IDLE  = 2'd0;
  localparam logic [1:0] M_SWEEP = 2'd1;
  localparam logic [1:0] M_END   = 2'd2;

  typedef struct packed {
    logic [1:0]  ph;
    int          n;
    logic [4:0]  pat;
    logic        busy;
    logic        done;
    logic [31:0] tt;
    logic [15:0] sig;
    logic [5:0]  ones;
  } m_t;

  typedef struct packed {
    logic [4:0]  pat;
    logic        busy;
    logic        done;
    logic [31:0] tt;
    logic [15:0] sig;
    logic [5:0]  ones;
  } o_t;

  logic CK = 1'b0;
  logic reset = 1'b1;
  logic st[3];
  logic ab[3];
  int   mode[3];
  m_t   m[3];
  o_t   obs[3];
  int   errors = 0;
  int   checks = 0;

  always #5 CK = ~CK;

  // mode 0: pattern[0], 1: tied 0, 2: tied 1, 3: AND of all bits
  function automatic logic resp(int md, int k);
    case (md)
      0:       return k[0];
      1:       return 1'b0;
      2:       return 1'b1;
      default: return (k == N - 1);
    endcase
  endfunction

  function automatic logic [15:0] misr(logic [15:0] s, logic r);
    return {s[14:0], 1'b0} ^ (s[15] ? POLY : 16'h0000) ^ {15'b0, r};
  endfunction

  function automatic m_t m_reset(logic [15:0] seed);
    m_t r;
    r = '0;
    r.sig = seed;
    return r;
  endfunction

  // n counts edges since the sweep started; the held pattern is n/dwell
  function automatic m_t m_step(m_t c, logic s, logic a, int dwell, logic [15:0] seed, int md);
    m_t   x;
    int   k;
    int   p;
    logic r;
    x = c;
    x.done = 1'b0;
    if (c.ph == M_IDLE) begin
      if (s) begin
        x = m_reset(seed);
        x.ph = M_SWEEP;
        x.busy = 1'b1;
      end
    end else if (c.ph == M_SWEEP) begin
      if (a) begin
        x.ph = M_IDLE;
        x.busy = 1'b0;
      end else begin
        x.n = c.n + 1;
        if (x.n % dwell == 0) begin
          k = c.n / dwell;
          r = resp(md, k);
          x.tt[k] = r;
          x.ones = c.ones + {5'b0, r};
          x.sig = misr(c.sig, r);
          if (k == N - 1) begin
            x.ph = M_END;
            x.busy = 1'b0;
            x.done = 1'b1;
          end
        end
        p = x.n / dwell;
        if (p > N - 1) p = N - 1;
        x.pat = p[4:0];
      end
    end else begin
      x.ph = M_IDLE;
    end
    return x;
  endfunction

  exhaustive_sweep_capture_if #(.W(W)) if0 ();
  exhaustive_sweep_capture_if #(.W(W)) if1 ();
  exhaustive_sweep_capture_if #(.W(W)) if2 ();

  exhaustive_sweep_capture #(.W(W), .DWELL(2), .POLY(POLY), .SEED(16'hFFFF))
    u0 (.CK(CK), .reset(reset), .bus(if0));
  exhaustive_sweep_capture #(.W(W), .DWELL(2), .POLY(POLY), .SEED(16'h0000))
    u1 (.CK(CK), .reset(reset), .bus(if1));
  exhaustive_sweep_capture #(.W(W), .DWELL(3), .POLY(POLY), .SEED(16'hFFFF))
    u2 (.CK(CK), .reset(reset), .bus(if2));

  assign if0.start = st[0];
  assign if1.start = st[1];
  assign if2.start = st[2];
  assign if0.abort = ab[0];
  assign if1.abort = ab[1];
  assign if2.abort = ab[2];
  assign if0.dut_out = resp(mode[0], int'(if0.pattern));
  assign if1.dut_out = resp(mode[1], int'(if1.pattern));
  assign if2.dut_out = resp(mode[2], int'(if2.pattern));

  assign obs[0] = {if0.pattern, if0.busy, if0.done, if0.truth_table, if0.signature, if0.ones_count};
  assign obs[1] = {if1.pattern, if1.busy, if1.done, if1.truth_table, if1.signature, if1.ones_count};
  assign obs[2] = {if2.pattern, if2.busy, if2.done, if2.truth_table, if2.signature, if2.ones_count};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  always @(posedge CK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) m[i] <= m_reset(SEEDS[i]);
    end else begin
      for (int i = 0; i < 3; i++) m[i] <= m_step(m[i], st[i], ab[i], DWS[i], SEEDS[i], mode[i]);
    end
  end

  always @(negedge CK) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("u%0d.pattern", i), 64'(obs[i].pat),  64'(m[i].pat));
        chk($sformatf("u%0d.busy", i),    64'(obs[i].busy), 64'(m[i].busy));
        chk($sformatf("u%0d.done", i),    64'(obs[i].done), 64'(m[i].done));
        chk($sformatf("u%0d.table", i),   64'(obs[i].tt),   64'(m[i].tt));
        chk($sformatf("u%0d.sig", i),     64'(obs[i].sig),  64'(m[i].sig));
        chk($sformatf("u%0d.ones", i),    64'(obs[i].ones), 64'(m[i].ones));
      end
    end
  end

  task automatic wait_done(input int i, output int edges);
    edges = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge CK);
      @(negedge CK);
      if (obs[i].done) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic run_sweep(input int i, output int edges);
    @(negedge CK);
    st[i] = 1'b1;
    @(posedge CK);
    @(negedge CK);
    st[i] = 1'b0;
    wait_done(i, edges);
  endtask

  initial begin
    int e;
    int pulses;
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0;
      ab[i] = 1'b0;
    end
    mode[0] = 0;
    mode[1] = 1;
    mode[2] = 3;

    #12;
    chk("rst.pattern", 64'(if0.pattern), 64'd0);
    chk("rst.busy", 64'(if0.busy), 64'd0);
    chk("rst.done", 64'(if0.done), 64'd0);
    chk("rst.table", 64'(if0.truth_table), 64'd0);
    chk("rst.sig", 64'(if0.signature), 64'hFFFF);
    chk("rst.ones", 64'(if0.ones_count), 64'd0);
    chk("rst.sig_seed0", 64'(if1.signature), 64'h0000);
    @(negedge CK);
    reset = 1'b0;

    // pattern[0] response
    run_sweep(0, e);
    chk("t1.done_edge", 64'(e), 64'd64);
    chk("t1.table", 64'(if0.truth_table), 64'hAAAAAAAA);
    chk("t1.ones", 64'(if0.ones_count), 64'd16);

    // tied responses with zero seed
    run_sweep(1, e);
    chk("t2a.done_edge", 64'(e), 64'd64);
    chk("t2a.table", 64'(if1.truth_table), 64'd0);
    chk("t2a.ones", 64'(if1.ones_count), 64'd0);
    chk("t2a.sig", 64'(if1.signature), 64'h0000);
    mode[1] = 2;
    run_sweep(1, e);
    chk("t2b.table", 64'(if1.truth_table), 64'hFFFFFFFF);
    chk("t2b.ones", 64'(if1.ones_count), 64'd32);
    chk("t2b.sig", 64'(if1.signature), 64'hE2F0);

    // AND response, DWELL=3
    run_sweep(2, e);
    chk("t3.done_edge", 64'(e), 64'd96);
    chk("t3.table", 64'(if2.truth_table), 64'h80000000);
    chk("t3.ones", 64'(if2.ones_count), 64'd1);

    // abort on edge 20 while pattern 9 awaits its sample
    @(negedge CK);
    st[0] = 1'b1;
    @(posedge CK);
    @(negedge CK);
    st[0] = 1'b0;
    repeat (19) begin
      @(posedge CK);
      @(negedge CK);
    end
    chk("t4.pattern_pre", 64'(if0.pattern), 64'd9);
    ab[0] = 1'b1;
    @(posedge CK);
    @(negedge CK);
    ab[0] = 1'b0;
    chk("t4.busy", 64'(if0.busy), 64'd0);
    chk("t4.done", 64'(if0.done), 64'd0);
    chk("t4.pattern", 64'(if0.pattern), 64'd9);
    chk("t4.table", 64'(if0.truth_table), 64'h000000AA);
    chk("t4.ones", 64'(if0.ones_count), 64'd4);
    run_sweep(0, e);
    chk("t4.redo_edge", 64'(e), 64'd64);
    chk("t4.redo_table", 64'(if0.truth_table), 64'hAAAAAAAA);

    // async reset between edges
    @(negedge CK);
    st[0] = 1'b1;
    @(posedge CK);
    @(negedge CK);
    st[0] = 1'b0;
    repeat (30) begin
      @(posedge CK);
      @(negedge CK);
    end
    #2;
    reset = 1'b1;
    #1;
    chk("t5.pattern", 64'(if0.pattern), 64'd0);
    chk("t5.busy", 64'(if0.busy), 64'd0);
    chk("t5.table", 64'(if0.truth_table), 64'd0);
    chk("t5.ones", 64'(if0.ones_count), 64'd0);
    chk("t5.sig", 64'(if0.signature), 64'hFFFF);
    @(negedge CK);
    reset = 1'b0;
    pulses = 0;
    repeat (80) begin
      @(posedge CK);
      @(negedge CK);
      if (if0.done) pulses++;
    end
    chk("t5.no_done", 64'(pulses), 64'd0);

    // start held high across sweeps
    @(negedge CK);
    st[0] = 1'b1;
    @(posedge CK);
    @(negedge CK);
    wait_done(0, e);
    chk("t6.done_edge", 64'(e), 64'd64);
    @(posedge CK);
    @(negedge CK);
    chk("t6.idle_busy", 64'(if0.busy), 64'd0);
    chk("t6.idle_done", 64'(if0.done), 64'd0);
    chk("t6.idle_table", 64'(if0.truth_table), 64'hAAAAAAAA);
    @(posedge CK);
    @(negedge CK);
    chk("t6.restart_busy", 64'(if0.busy), 64'd1);
    chk("t6.restart_table", 64'(if0.truth_table), 64'd0);
    chk("t6.restart_ones", 64'(if0.ones_count), 64'd0);
    chk("t6.restart_pattern", 64'(if0.pattern), 64'd0);
    repeat (10) begin
      @(posedge CK);
      @(negedge CK);
    end
    chk("t6.mid_busy", 64'(if0.busy), 64'd1);
    chk("t6.mid_pattern", 64'(if0.pattern), 64'd5);
    st[0] = 1'b0;
    ab[0] = 1'b1;
    @(posedge CK);
    @(negedge CK);
    ab[0] = 1'b0;
    repeat (4) begin
      @(posedge CK);
      @(negedge CK);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exhaustive_sweep_capture.md
Name: exhaustive_sweep_capture

Overview:
- Hardware stimulus and response stage wrapped around a small benchmark circuit under trojan analysis.
- Drives every W-bit input pattern in ascending binary order, holding each pattern for DWELL cycles.
- Samples the circuit's single-bit output at the end of each dwell and packs the responses into a 2^W-bit truth table.
- Also compacts the responses into a 16-bit MISR signature and a ones count, so golden and suspect circuits compare with one read.

Parameters:
- W, 5, number of circuit input bits (1..8).
- DWELL, 2, cycles each pattern is held; the last cycle is the sample cycle (>=1).
- POLY, 16'h1021, MISR feedback polynomial (x^16+x^12+x^5+1).
- SEED, 16'hFFFF, MISR value at reset and at sweep start.

Ports:
- CK  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a sweep; honoured only in IDLE.
- abort  input  1  stop the sweep; honoured only in DRIVE.
- dut_out  input  1  single-bit response of the circuit under test.
- pattern  output  W  stimulus; pattern[W-1] drives the circuit's first (MSB) input.
- busy  output  1  high while in DRIVE.
- done  output  1  one-cycle pulse when a full sweep completes.
- truth_table  output  2^W  bit k = response to pattern k.
- signature  output  16  MISR result.
- ones_count  output  W+1  number of responses equal to 1.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; pattern = 0; dwell_cnt = 0; busy = 0; done = 0.
  - truth_table = 0; signature = SEED; ones_count = 0.
- States: IDLE, DRIVE, DONE. All outputs are registered.
- IDLE, start = 1 (clock edge e0):
  - pattern = 0, dwell_cnt = 0, truth_table = 0, signature = SEED, ones_count = 0.
  - busy = 1; next state DRIVE.
- IDLE, start = 0: all outputs hold; the previous results stay readable.
- DRIVE, each edge:
  - If dwell_cnt != DWELL-1: dwell_cnt increments.
  - Else (sample edge):
    - truth_table[pattern] = dut_out.
    - ones_count += dut_out.
    - signature = {signature[14:0], 1'b0} ^ (signature[15] ? POLY : 0) ^ {15'b0, dut_out}.
    - If pattern == 2^W-1: busy = 0, done = 1, next state DONE; pattern holds at 2^W-1.
    - Else: pattern increments, dwell_cnt = 0.
- Timing:
  - Pattern k is sampled at edge e_((k+1)*DWELL).
  - done is high for the cycle after edge e_(2^W*DWELL). With defaults, that is edge 64.
- DONE: done = 1 for exactly one cycle, then IDLE. start is ignored in DONE; it is accepted on the following IDLE cycle.
- start during DRIVE is ignored.
- abort in DRIVE:
  - Next edge: state = IDLE, busy = 0, no done pulse.
  - truth_table, signature and ones_count keep their partial values; pattern holds.
  - If abort and the final sample edge coincide, abort wins: the final sample is not taken and done stays 0.
- abort outside DRIVE is ignored.
- dut_out is only sampled on sample edges. Setting DWELL > 1 absorbs circuit latency up to DWELL-1 cycles.
- Width rules:
  - ones_count max is 2^W and fits in W+1 bits; no saturation is needed.
  - pattern wrap-around never occurs; the sweep terminates at 2^W-1.
- reset mid-sweep: clears immediately; no done pulse is produced.

Test Plan:
1. W=5, DWELL=2, dut_out = pattern[0], pulse start -> done at edge 64 after start, truth_table = 32'hAAAAAAAA, ones_count = 16, busy high for edges 1..64.
2. SEED = 16'h0000, dut_out tied 0 -> truth_table = 0, ones_count = 0, signature = 16'h0000; dut_out tied 1 -> truth_table = 32'hFFFFFFFF, ones_count = 32, signature matches the bench MISR model.
3. dut_out = AND of all pattern bits, DWELL=3 -> truth_table = 32'h80000000, ones_count = 1, done at edge 96; pattern steps every 3 cycles.
4. abort at edge 20 (pattern = 9, defaults) -> busy low next cycle, no done, pattern stays 9, truth_table bits 0..8 valid and higher bits 0; then start again -> clean full sweep.
5. reset asserted asynchronously between edges mid-sweep -> pattern, busy, truth_table, ones_count go to 0 and signature to SEED before the next edge; no done.
6. start held high continuously -> first sweep completes with done, the next sweep starts on the IDLE cycle after DONE, results clear, and start is ignored during DRIVE.
